// File: rtl/xf100_ifetch.sv
// Instruction fetch front end: issues word-aligned fetches with at most two
// instructions in flight or buffered, drops stale responses after a redirect.
module xf100_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_err
);

    localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

    logic        started;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    logic [1:0]  inflight;
    logic [1:0]  drop;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        fifo_err   [2];

    logic [31:0] redirect_aligned;
    logic [2:0]  occupancy;
    logic        req_fire;
    logic        rsp_fire;
    logic        keep;
    logic        pop;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign occupancy        = {1'b0, inflight} + {1'b0, count};

    // Occupancy uses registered counts only, so the request never depends on
    // same-cycle responses or pops.
    assign imem_req_valid = started & ~redirect_valid & (occupancy < 3'd2);
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid & (inflight != 2'd0);
    assign keep     = rsp_fire & (drop == 2'd0) & ~redirect_valid;
    assign pop      = out_valid & out_ready & ~redirect_valid;

    assign out_valid = (count != 2'd0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_err   = fifo_err[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started       <= 1'b0;
            fetch_pc      <= START_PC;
            rsp_pc        <= START_PC;
            inflight      <= 2'd0;
            drop          <= 2'd0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_pc[0]    <= 32'd0;
            fifo_pc[1]    <= 32'd0;
            fifo_instr[0] <= 32'd0;
            fifo_instr[1] <= 32'd0;
            fifo_err[0]   <= 1'b0;
            fifo_err[1]   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                // Every response still owed by memory belongs to the old stream.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                inflight <= inflight - {1'b0, rsp_fire};
                drop     <= inflight - {1'b0, rsp_fire};
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                inflight <= inflight + {1'b0, req_fire} - {1'b0, rsp_fire};
                if (rsp_fire && (drop != 2'd0)) begin
                    drop <= drop - 2'd1;
                end
                if (keep) begin
                    fifo_pc[wr_ptr]    <= rsp_pc;
                    fifo_instr[wr_ptr] <= imem_rsp_instr;
                    fifo_err[wr_ptr]   <= imem_rsp_err;
                    wr_ptr             <= ~wr_ptr;
                    rsp_pc             <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, keep} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_xf100_ifetch.sv
// Scoreboard bench for xf100_ifetch: directed scenarios push expected requests
// and instructions; monitors compare whenever the DUT handshakes.
module tb_xf100_ifetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_err;

    xf100_ifetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_err        (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        exp_out[$];
    logic [31:0] exp_req[$];
    mreq_t       mq[$];

    int          errors = 0;
    int          checks = 0;
    int          allow = 0;
    int          mem_rel = 1000;
    int          cyc = 0;
    logic [31:0] err_addr = 32'h0000_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        exp_out.push_back({pc, instr, err});
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_req.size() != 0 || mq.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out_left", exp_out.size(), 0);
        chk("drain_req_left", exp_req.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Memory model: in-order, 1-cycle minimum latency, responses gated by mem_rel,
    // acceptance gated by allow.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = 32'd0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_instr = 32'd0;
            imem_rsp_err   = 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc && mem_rel > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_instr = mq[0].addr ^ 32'hDEAD_0000;
                imem_rsp_err   = (mq[0].addr == err_addr);
                void'(mq.pop_front());
                mem_rel--;
            end
            imem_req_ready = (allow > 0);
            #1;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                mq.push_back({imem_req_addr, cyc + 1});
                allow--;
            end
        end
    end

    initial begin
        logic        hold_out;
        logic        hold_req;
        logic [31:0] p_pc;
        logic [31:0] p_instr;
        logic [31:0] p_addr;
        logic        p_err;
        exp_t        e;
        logic [31:0] ea;
        hold_out = 1'b0;
        hold_req = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                hold_out = 1'b0;
                hold_req = 1'b0;
            end else begin
                if (hold_out) begin
                    chk("out_hold_valid", out_valid, 1);
                    chk("out_hold_pc", out_pc, p_pc);
                    chk("out_hold_instr", out_instr, p_instr);
                    chk("out_hold_err", out_err, p_err);
                end
                if (hold_req && imem_req_valid) chk("req_hold_addr", imem_req_addr, p_addr);
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected actual pc=%h instr=%h required none", out_pc, out_instr);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_instr", out_instr, e.instr);
                        chk("out_err", out_err, e.err);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected actual addr=%h required none", imem_req_addr);
                    end else begin
                        ea = exp_req.pop_front();
                        chk("req_addr", imem_req_addr, ea);
                    end
                end
                hold_out = out_valid & ~out_ready & ~redirect_valid;
                hold_req = imem_req_valid & ~imem_req_ready & ~redirect_valid;
                p_pc     = out_pc;
                p_instr  = out_instr;
                p_err    = out_err;
                p_addr   = imem_req_addr;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("prestart_req_valid", imem_req_valid, 0);

        // Streaming fetch from RESET_PC
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(32'h0000_0100 + 32'(4 * i));
            push_out(32'h0000_0100 + 32'(4 * i), 32'hDEAD_0100 + 32'(4 * i), 1'b0);
        end
        allow = 4;
        drain(100);
        chk("stream_out_valid_end", out_valid, 0);

        // Backpressure: FIFO fills after two requests
        out_ready = 1'b0;
        exp_req.push_back(32'h0000_0110);
        exp_req.push_back(32'h0000_0114);
        allow = 10;
        repeat (6) @(negedge clk);
        #3;
        chk("full_req_left", exp_req.size(), 0);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_pc", out_pc, 32'h0000_0110);
        chk("full_out_instr", out_instr, 32'hDEAD_0110);
        @(negedge clk);
        exp_req.push_back(32'h0000_0118);
        push_out(32'h0000_0110, 32'hDEAD_0110, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        chk("refill_req_left", exp_req.size(), 0);
        chk("refill_req_valid", imem_req_valid, 0);
        chk("refill_out_pc", out_pc, 32'h0000_0114);
        @(negedge clk);
        allow = 0;
        push_out(32'h0000_0114, 32'hDEAD_0114, 1'b0);
        push_out(32'h0000_0118, 32'hDEAD_0118, 1'b0);
        out_ready = 1'b1;
        drain(100);

        // Redirect with two requests outstanding
        mem_rel = 0;
        exp_req.push_back(32'h0000_011C);
        exp_req.push_back(32'h0000_0120);
        allow = 2;
        repeat (5) @(negedge clk);
        #3;
        chk("outstanding_req_valid", imem_req_valid, 0);
        do_redirect(32'h0000_2002);
        exp_req.push_back(32'h0000_2000);
        exp_req.push_back(32'h0000_2004);
        push_out(32'h0000_2000, 32'hDEAD_2000, 1'b0);
        push_out(32'h0000_2004, 32'hDEAD_2004, 1'b0);
        mem_rel = 1000;
        allow = 2;
        drain(100);

        // Redirect coinciding with a response, then a second redirect mid-drop
        mem_rel = 0;
        exp_req.push_back(32'h0000_2008);
        exp_req.push_back(32'h0000_200C);
        allow = 2;
        repeat (5) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        mem_rel        = 1;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_rel        = 0;
        exp_req.push_back(32'h0000_3000);
        allow = 1;
        repeat (3) @(negedge clk);
        do_redirect(32'h0000_4000);
        exp_req.push_back(32'h0000_4000);
        exp_req.push_back(32'h0000_4004);
        push_out(32'h0000_4000, 32'hDEAD_4000, 1'b0);
        push_out(32'h0000_4004, 32'hDEAD_4004, 1'b0);
        mem_rel = 1000;
        allow = 2;
        drain(100);

        // Address wrap and a faulting fetch in the middle of the stream
        err_addr = 32'h0000_0000;
        do_redirect(32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0004);
        push_out(32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0);
        push_out(32'h0000_0000, 32'hDEAD_0000, 1'b1);
        push_out(32'h0000_0004, 32'hDEAD_0004, 1'b0);
        allow = 3;
        drain(100);
        err_addr = 32'h0000_0001;

        // Reset mid-operation with responses arriving during reset
        mem_rel = 0;
        exp_req.push_back(32'h0000_0008);
        exp_req.push_back(32'h0000_000C);
        allow = 2;
        repeat (4) @(negedge clk);
        chk("midrst_req_left", exp_req.size(), 0);
        allow   = 0;
        mem_rel = 1000;
        rst_n   = 1'b0;
        #3;
        chk("midrst_req_valid", imem_req_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_pc", out_pc, 0);
        repeat (3) @(negedge clk);
        #3;
        chk("midrst_out_valid_late", out_valid, 0);
        chk("midrst_out_instr", out_instr, 0);
        @(negedge clk);
        mq.delete();
        rst_n = 1'b1;
        exp_req.push_back(32'h0000_0100);
        exp_req.push_back(32'h0000_0104);
        push_out(32'h0000_0100, 32'hDEAD_0100, 1'b0);
        push_out(32'h0000_0104, 32'hDEAD_0104, 1'b0);
        allow = 2;
        drain(100);
        chk("final_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xf100_ifetch.md
XF100_IFETCH -- requirements
Module: xf100_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset; bits [1:0] are ignored and treated as 0.
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port redirect_valid  input  1  flush and restart fetch.
REQ-005 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] are forced to 0.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-008 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-009 SHALL have port imem_rsp_valid  input  1  response valid; responses arrive in order, at least 1 cycle after request acceptance, with no backpressure.
REQ-010 SHALL have port imem_rsp_instr  input  32  fetched instruction.
REQ-011 SHALL have port imem_rsp_err  input  1  fetch fault flag.
REQ-012 SHALL have port out_valid  output  1  instruction available to decode.
REQ-013 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-014 SHALL have port out_instr  output  32  instruction.
REQ-015 SHALL have port out_pc  output  32  PC of out_instr.
REQ-016 SHALL have port out_err  output  1  fault flag of out_instr.

Function
REQ-017 SHALL hold: fetch_pc (next request address), rsp_pc (PC of next kept response), inflight counter 0..2, drop counter 0..inflight, 2-entry FIFO of {pc, instr, err}, and a started flag.
REQ-018 SHALL set started=1 on the first clk edge after rst_n release; imem_req_valid SHALL be 0 while started=0.
REQ-019 SHALL drive imem_req_valid = started & !redirect_valid & (inflight + fifo_count < 2), computed from registered counts only, with imem_req_addr = fetch_pc.
REQ-020 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, unless redirect_valid=1.
REQ-021 SHALL, on request handshake (valid & ready), increment fetch_pc by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and increment inflight.
REQ-022 SHALL, on imem_rsp_valid, decrement inflight; if drop>0, decrement drop and discard the data, else push {rsp_pc, imem_rsp_instr, imem_rsp_err} into the FIFO and increment rsp_pc by 4 modulo 2^32.
REQ-023 SHALL present the FIFO head on out_*; out_valid = FIFO not empty; a pushed entry is visible no earlier than the cycle after imem_rsp_valid (no bypass).
REQ-024 SHALL pop the FIFO on out_valid & out_ready; a push and a pop in the same cycle SHALL both take effect with fifo_count unchanged.
REQ-025 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on redirect_valid, clear the FIFO, set fetch_pc and rsp_pc to {redirect_pc[31:2],2'b00}, and set drop = inflight - imem_rsp_valid; a response in the redirect cycle SHALL be discarded.
REQ-027 SHALL, on a redirect while drops are pending, recompute drop per REQ-026, so every outstanding pre-redirect response is discarded.
REQ-028 SHALL treat an out handshake in the redirect cycle as consumed; the FIFO flush takes priority over any pop or push.
REQ-029 SHALL pass imem_rsp_err through unchanged and SHALL NOT stall fetch because of it.
REQ-030 SHALL never let inflight + fifo_count exceed 2.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force started=0, inflight=0, drop=0, FIFO empty, fetch_pc=rsp_pc=RESET_PC, imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, out_err=0.
REQ-032 SHALL discard all state when reset is asserted mid-operation; responses arriving during reset SHALL be ignored.

Verification
REQ-033 Reset release, RESET_PC=0x100, req_ready=1, 1-cycle response latency, out_ready=1 -> req addrs 0x100, 0x104, 0x108...; out_pc 0x100, 0x104 in order with matching instr.
REQ-034 out_ready=0 held -> exactly 2 requests issued; imem_req_valid=0 while FIFO is full; out_* stable; after one pop, exactly one new request is issued.
REQ-035 redirect_pc=0x2002 with 2 requests outstanding -> both responses dropped; next out_pc=0x2000; first new req addr=0x2000.
REQ-036 Redirect in the same cycle as a response, then a second redirect before the drops drain -> no stale instruction ever reaches out_valid.
REQ-037 fetch_pc=0xFFFF_FFFC -> next req addr=0x0000_0000; out_pc wraps identically.
REQ-038 imem_rsp_err=1 on one response -> that entry has out_err=1 and fetch continues uninterrupted.
